l1_wishbone_burst_bridge: RTL and testbench
===========================================

Name: l1_wishbone_burst_bridge

Overview:
- Converts L1 arbiter requests (addr/data/rnw/be/size) into Wishbone B4 registered-feedback cycles on a single master port.
- Reads: incrementing or wrapping bursts (cti/bte). Writes: single-beat.
- Includes a per-beat timeout watchdog that aborts hung cycles and reports an error.
- Sits between the L1 arbiter and an external Wishbone fabric. Successor to the fixed-width, single-beat Wishbone master path: data width, burst length and wrap mode are parametrised, and error/timeout handling is added.

Parameters:
- DATA_W, 32, Wishbone data width in bits; must be 32 or 64.
- ADDR_W, 32, byte-address width of the request side.
- MAX_BURST, 8, maximum read beats per cycle; power of two, 1..16.
- WRAP_MODE, 0, 0 = linear burst (bte=00); 1 = wrap burst aligned to MAX_BURST words (bte=01/10/11 for 4/8/16).
- TIMEOUT_CYCLES, 256, cycles without ack/err before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request present (L1 arbiter "request").
- req_ack  out  1  request accepted this cycle.
- req_addr  in  ADDR_W  byte address.
- req_data  in  DATA_W  write data.
- req_rnw  in  1  1 = read, 0 = write.
- req_be  in  DATA_W/8  byte enables (writes only).
- req_size  in  5  read beats minus 1.
- rsp_data  out  DATA_W  read beat data.
- rsp_valid  out  1  rsp_data valid (one pulse per beat).
- rsp_err  out  1  one-cycle pulse on bus error or timeout.
- wb_adr  out  ADDR_W-log2(DATA_W/8)  word address.
- wb_dat_w  out  DATA_W  write data.
- wb_sel  out  DATA_W/8  byte select.
- wb_cyc  out  1  cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  write enable.
- wb_cti  out  3  cycle type.
- wb_bte  out  2  burst type.
- wb_dat_r  in  DATA_W  read data.
- wb_ack  in  1  acknowledge.
- wb_err  in  1  error.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-low (rst).
- Reset values (rst=0 at a clock edge): wb_cyc=0, wb_stb=0, wb_we=0, wb_cti=000, wb_bte=00, wb_adr=0, wb_sel=0, wb_dat_w=0, rsp_valid=0, rsp_err=0, rsp_data=0; FSM returns to IDLE.
- Reset mid-cycle: cyc/stb drop on that edge; no rsp_valid or rsp_err is produced for the aborted cycle.
- FSM states: IDLE, READ, WRITE, ABORT.
- IDLE:
  - req_ack = req_valid (combinational, IDLE only).
  - On accept, latch fields; next cycle assert cyc=stb=1.
  - Go to READ if req_rnw=1, else WRITE.
- READ:
  - beats = min(req_size+1, MAX_BURST).
  - beats=1: cti=000 (classic).
  - beats>1: cti=010 on all beats except the last, 111 on the last.
  - wb_sel = all ones; bte from WRAP_MODE (00 if WRAP_MODE=0).
- Per ack in READ:
  - rsp_data <= wb_dat_r and rsp_valid=1 on the following cycle (1-cycle latency).
  - Address advances: linear adds 1 word; wrap increments only the low log2(MAX_BURST) bits.
  - Beat counter decrements.
  - On the last ack: cyc/stb=0 next cycle, go to IDLE.
- WRITE:
  - cti=000, we=1, sel=req_be, dat_w=req_data.
  - On ack: cyc/stb=0 next cycle, go to IDLE; no rsp_valid.
- wb_err in READ or WRITE:
  - Go to ABORT: cyc/stb=0 next cycle, rsp_err pulses 1 cycle.
  - Remaining read beats are not returned.
  - ABORT lasts 1 cycle, then IDLE.
- ack and err in the same cycle: err wins; data is discarded, no rsp_valid.
- Watchdog:
  - Counter clears on cycle start and on every ack.
  - When it reaches TIMEOUT_CYCLES with cyc=1, take the same path as wb_err.
  - Counter width = clog2(TIMEOUT_CYCLES+1).
  - TIMEOUT_CYCLES=0 disables the watchdog; counter not instantiated.
- wb_cyc is deasserted for at least 1 cycle between transactions.
- req_ack never asserts outside IDLE.
- Outputs stable while stb=1 and ack=0 (classic/B4 hold rule).

Decomposition:
- Shared package (extend l2_config_and_types or new wishbone_types):
  - cti constants: CLASSIC=000, INCR=010, END=111.
  - bte encoding function from MAX_BURST.
  - bridge_state_t enum {IDLE, READ, WRITE, ABORT}.
- One sub-module: wb_burst_addr_gen (word address register, linear/wrap increment, beat counter, last-beat flag).

Test Plan:
- Single write: addr=0x1000, data=0xDEADBEEF, be=0011 -> wb_adr=0x400, sel=0011, we=1, cti=000; ack after 2 cycles -> cyc low next cycle; no rsp_valid.
- Linear read burst: WRAP_MODE=0, addr=0x2000, size=3 -> adr 0x800..0x803, cti 010,010,010,111; 4 rsp_valid pulses, data in order, each 1 cycle after its ack.
- Wrap read burst: WRAP_MODE=1, MAX_BURST=4, addr=0x3008, size=3 -> adr 0xC02, 0xC03, 0xC00, 0xC01, bte=01.
- Error mid-burst: size=7, wb_err on 3rd beat together with ack -> 2 rsp_valid pulses, 1 rsp_err pulse, cyc low next cycle, req_ack=1 again on the following cycle.
- Timeout: TIMEOUT_CYCLES=16, slave never acks -> cyc drops exactly 16 cycles after cycle start; rsp_err=1 for 1 cycle.
- Reset mid-burst: rst=0 during beat 2 of 8 -> all outputs at reset values next edge; no further rsp_valid; after release, a new read of size=0 completes normally with cti=000.

Source files
------------

// File: rtl/l1_wishbone_burst_bridge_pkg.sv
// Shared types and constants for the L1-to-Wishbone burst bridge.
package l1_wishbone_burst_bridge_pkg;

    // Wishbone B4 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ABORT
    } bridge_state_t;

    // Burst type for a wrap burst of max_burst words; sizes with no
    // B4 wrap encoding fall back to linear.
    function automatic logic [1:0] wrap_bte(input int max_burst);
        case (max_burst)
            4:       return 2'b01;
            8:       return 2'b10;
            16:      return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/l1_wishbone_burst_bridge_wb_burst_addr_gen.sv
// Word address register and beat counter for one Wishbone burst.
// Wrap mode only advances the low log2(MAX_BURST) address bits.
module wb_burst_addr_gen #(
    parameter int AW        = 30,
    parameter int MAX_BURST = 8,
    parameter int WRAP_MODE = 0,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [AW-1:0]    start_adr,
    input  logic [CNT_W-1:0] beats_m1,
    output logic [AW-1:0]    adr,
    output logic             last
);

    localparam logic [AW-1:0] WRAP_MASK = AW'(MAX_BURST - 1);

    logic [AW-1:0]    adr_q, adr_d, adr_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next address/count: load at accept, step once per accepted beat
    always_comb begin
        adr_inc = adr_q + 1'b1;
        if (WRAP_MODE != 0) begin
            adr_inc = (adr_q & ~WRAP_MASK) | (adr_inc & WRAP_MASK);
        end
        adr_d = adr_q;
        cnt_d = cnt_q;
        if (load) begin
            adr_d = start_adr;
            cnt_d = beats_m1;
        end else if (advance) begin
            adr_d = adr_inc;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Address and remaining-beat registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            adr_q <= '0;
            cnt_q <= '0;
        end else begin
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign adr  = adr_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/l1_wishbone_burst_bridge.sv
// L1 arbiter request to Wishbone B4 master: burst reads, single writes,
// bus-error and per-beat timeout abort with a one-cycle error pulse.
module l1_wishbone_burst_bridge import l1_wishbone_burst_bridge_pkg::*; #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int MAX_BURST      = 8,
    parameter int WRAP_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ack,
    input  logic [ADDR_W-1:0]                     req_addr,
    input  logic [DATA_W-1:0]                     req_data,
    input  logic                                  req_rnw,
    input  logic [DATA_W/8-1:0]                   req_be,
    input  logic [4:0]                            req_size,
    output logic [DATA_W-1:0]                     rsp_data,
    output logic                                  rsp_valid,
    output logic                                  rsp_err,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]    wb_adr,
    output logic [DATA_W-1:0]                     wb_dat_w,
    output logic [DATA_W/8-1:0]                   wb_sel,
    output logic                                  wb_cyc,
    output logic                                  wb_stb,
    output logic                                  wb_we,
    output logic [2:0]                            wb_cti,
    output logic [1:0]                            wb_bte,
    input  logic [DATA_W-1:0]                     wb_dat_r,
    input  logic                                  wb_ack,
    input  logic                                  wb_err
);

    localparam int         SEL_W   = DATA_W / 8;
    localparam int         OFF     = $clog2(SEL_W);
    localparam int         WB_AW   = ADDR_W - OFF;
    localparam logic [4:0] MAXB_M1 = 5'(MAX_BURST - 1);

    bridge_state_t     state_q, state_d;
    logic              load, advance, last, cyc, timeout, fault;
    logic [4:0]        beats_m1;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] dat_q, dat_d, rsp_data_q, rsp_data_d;
    logic              burst_q, burst_d, rsp_valid_q, rsp_valid_d;
    logic              unused_addr_lsb;

    // Byte offset within a bus word never reaches the bus
    assign unused_addr_lsb = ^req_addr[OFF-1:0];

    assign beats_m1 = (req_size > MAXB_M1) ? MAXB_M1 : req_size;
    assign cyc      = (state_q == READ) || (state_q == WRITE);
    assign fault    = wb_err || timeout;

    wb_burst_addr_gen #(
        .AW        (WB_AW),
        .MAX_BURST (MAX_BURST),
        .WRAP_MODE (WRAP_MODE),
        .CNT_W     (5)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .start_adr (req_addr[ADDR_W-1:OFF]),
        .beats_m1  (beats_m1),
        .adr       (wb_adr),
        .last      (last)
    );

    // Watchdog: clears at cycle start and on each ack; fires one edge
    // before the count would reach the limit so cyc drops on schedule.
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [WD_W-1:0] wdog_q, wdog_d;

        // Count cycles spent waiting on the current beat
        always_comb begin
            wdog_d = wdog_q;
            if (load || wb_ack) begin
                wdog_d = '0;
            end else if (cyc) begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        // Watchdog counter register
        always_ff @(posedge clk) begin
            if (!rst) wdog_q <= '0;
            else      wdog_q <= wdog_d;
        end

        assign timeout = cyc && !wb_ack && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
        assign timeout = 1'b0;
    end

    // Next state and handshake; error outranks a simultaneous ack
    always_comb begin
        state_d = state_q;
        req_ack = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                req_ack = req_valid;
                if (req_valid) begin
                    load    = 1'b1;
                    state_d = req_rnw ? READ : WRITE;
                end
            end
            READ: begin
                if (fault) begin
                    state_d = ABORT;
                end else if (wb_ack) begin
                    advance = 1'b1;
                    if (last) state_d = IDLE;
                end
            end
            WRITE: begin
                if (fault)       state_d = ABORT;
                else if (wb_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields captured at accept; read data registered per beat
    always_comb begin
        sel_d       = sel_q;
        dat_d       = dat_q;
        burst_d     = burst_q;
        rsp_valid_d = advance;
        rsp_data_d  = advance ? wb_dat_r : rsp_data_q;
        if (load) begin
            sel_d   = req_rnw ? '1 : req_be;
            burst_d = req_rnw && (beats_m1 != 5'd0);
            if (!req_rnw) dat_d = req_data;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            dat_q       <= '0;
            burst_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            burst_q     <= burst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign wb_cyc    = cyc;
    assign wb_stb    = cyc;
    assign wb_we     = (state_q == WRITE);
    assign wb_sel    = sel_q;
    assign wb_dat_w  = dat_q;
    assign wb_cti    = (state_q == READ && burst_q) ? (last ? CTI_END : CTI_INCR) : CTI_CLASSIC;
    assign wb_bte    = (state_q == READ && WRAP_MODE != 0) ? wrap_bte(MAX_BURST) : 2'b00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = (state_q == ABORT);

endmodule

// File: tb/tb_l1_wishbone_burst_bridge.sv
// Scoreboard bench: the stimulus side queues expected bus beats and
// responses from a word-level model; a slave process and a response
// monitor pop and compare as the DUT presents them.
module tb_l1_wishbone_burst_bridge;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXB = 8;
    localparam int WRAP = 1;
    localparam int TO   = 16;
    localparam int SW   = DW / 8;
    localparam int WAW  = AW - 2;
    localparam logic [1:0] BTE_EXP = 2'b10;   // 8-word wrap

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ack;
    logic [AW-1:0]  req_addr = '0;
    logic [DW-1:0]  req_data = '0;
    logic           req_rnw = 1'b0;
    logic [SW-1:0]  req_be = '0;
    logic [4:0]     req_size = '0;
    logic [DW-1:0]  rsp_data;
    logic           rsp_valid, rsp_err;
    logic [WAW-1:0] wb_adr;
    logic [DW-1:0]  wb_dat_w;
    logic [SW-1:0]  wb_sel;
    logic           wb_cyc, wb_stb, wb_we;
    logic [2:0]     wb_cti;
    logic [1:0]     wb_bte;
    logic [DW-1:0]  wb_dat_r = '0;
    logic           wb_ack = 1'b0;
    logic           wb_err = 1'b0;

    always #5 clk = ~clk;

    l1_wishbone_burst_bridge #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MAXB), .WRAP_MODE(WRAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ack(req_ack), .req_addr(req_addr), .req_data(req_data),
        .req_rnw(req_rnw), .req_be(req_be), .req_size(req_size),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    typedef struct {
        logic [WAW-1:0] adr;
        logic [2:0]     cti;
        logic [1:0]     bte;
        logic           we;
        logic [SW-1:0]  sel;
        logic [DW-1:0]  dat;
    } beat_t;

    typedef struct {
        bit            err;
        logic [DW-1:0] data;
    } rsp_t;

    beat_t exp_beat_q[$];
    rsp_t  exp_rsp_q[$];
    int    ack_cyc_q[$];

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int cfg_delay = 0;
    int cfg_err_beat = 0;
    bit cfg_hang = 1'b0;
    int wcnt = 0;
    int sbeat = 0;
    bit prev_cyc = 1'b0;

    function automatic logic [DW-1:0] rd_fn(input logic [WAW-1:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Slave: acks after cfg_delay wait cycles, checks the presented beat
    // (every wait cycle too, so any change while stalled is caught).
    always @(negedge clk) begin
        beat_t e;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_r = $urandom;
        if (wb_cyc && wb_stb) begin
            if (!prev_cyc) begin
                wcnt  = cfg_delay;
                sbeat = 0;
            end
            if (!cfg_hang) begin
                chk("bus_beat_expected", exp_beat_q.size() != 0, 1);
                if (exp_beat_q.size() != 0) begin
                    e = exp_beat_q[0];
                    chk("bus_adr", wb_adr, e.adr);
                    chk("bus_ctl", {wb_cti, wb_bte, wb_we, wb_sel}, {e.cti, e.bte, e.we, e.sel});
                    if (e.we) chk("bus_dat_w", wb_dat_w, e.dat);
                    if (wcnt == 0) begin
                        void'(exp_beat_q.pop_front());
                        sbeat++;
                        wb_ack   = 1'b1;
                        wb_err   = (sbeat == cfg_err_beat);
                        wb_dat_r = rd_fn(wb_adr);
                        if (!e.we && !wb_err) ack_cyc_q.push_back(cyc_cnt);
                        wcnt = cfg_delay;
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
        prev_cyc = wb_cyc;
    end

    // Response monitor
    always @(negedge clk) begin
        rsp_t r;
        int   ac;
        if (rst && (rsp_valid || rsp_err)) begin
            chk("rsp_expected", exp_rsp_q.size() != 0, 1);
            if (exp_rsp_q.size() != 0) begin
                r = exp_rsp_q.pop_front();
                if (r.err) begin
                    chk("rsp_err_pulse", {rsp_err, rsp_valid}, 2'b10);
                end else begin
                    chk("rsp_valid_pulse", {rsp_err, rsp_valid}, 2'b01);
                    chk("rsp_data", rsp_data, r.data);
                    ac = (ack_cyc_q.size() != 0) ? ack_cyc_q.pop_front() : -100;
                    chk("rsp_latency", cyc_cnt - ac, 1);
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bus"}, {wb_cyc, wb_stb, wb_we, wb_cti, wb_bte, wb_adr, wb_sel}, 64'd0);
        chk({tag, "_data"}, {wb_dat_w, rsp_data}, 64'd0);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 64'd0);
    endtask

    // Word-level model: queue the beats the bus should show and the
    // responses the L1 side should see. Returns whether it aborts.
    task automatic expect_txn(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] be, input logic [4:0] size,
                              input int err_beat, input bit hang, output bit aborted);
        int             beats, n_bus;
        logic [WAW-1:0] w0, a;
        beat_t          b;
        rsp_t           r;
        beats   = rnw ? ((int'(size) + 1 > MAXB) ? MAXB : int'(size) + 1) : 1;
        aborted = hang || (err_beat >= 1 && err_beat <= beats);
        n_bus   = hang ? 0 : (aborted ? err_beat : beats);
        w0      = addr[AW-1:2];
        for (int i = 0; i < n_bus; i++) begin
            if (WRAP != 0) a = WAW'((w0 / MAXB) * MAXB + (w0 + i) % MAXB);
            else           a = WAW'(w0 + i);
            b.adr = a;
            b.we  = !rnw;
            b.sel = rnw ? '1 : be;
            b.dat = data;
            b.bte = (rnw && WRAP != 0) ? BTE_EXP : 2'b00;
            b.cti = (!rnw || beats == 1) ? 3'b000 : ((i == beats - 1) ? 3'b111 : 3'b010);
            exp_beat_q.push_back(b);
            r.err  = (i + 1 == err_beat);
            r.data = rd_fn(a);
            if (rnw || r.err) exp_rsp_q.push_back(r);
        end
        if (hang) begin
            r.err  = 1'b1;
            r.data = '0;
            exp_rsp_q.push_back(r);
        end
    endtask

    task automatic issue(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] be, input logic [4:0] size);
        @(negedge clk);
        #1;
        req_rnw = rnw; req_addr = addr; req_data = data; req_be = be; req_size = size;
        req_valid = 1'b1;
        #1 chk("req_ack_idle", req_ack, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("cyc_start", {wb_cyc, wb_stb}, 2'b11);
    endtask

    task automatic run_txn(input bit rnw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] be, input logic [4:0] size,
                           input int delay, input int err_beat, input bit hang);
        bit aborted;
        int cyc_len;
        expect_txn(rnw, addr, data, be, size, err_beat, hang, aborted);
        cfg_delay    = delay;
        cfg_err_beat = err_beat;
        cfg_hang     = hang;
        issue(rnw, addr, data, be, size);
        cyc_len = 0;
        for (int g = 0; g < 200 && wb_cyc; g++) begin
            cyc_len++;
            @(negedge clk);
        end
        chk("cyc_ends", wb_cyc, 0);
        if (hang) chk("timeout_len", cyc_len, TO);
        // Brief req_valid pulses (dropped before the edge) probe req_ack
        #2 req_valid = 1'b1;
        #1 chk("req_ack_after", req_ack, !aborted);
        req_valid = 1'b0;
        @(negedge clk);
        #2 req_valid = 1'b1;
        #1 chk("req_ack_reopen", req_ack, 1);
        req_valid = 1'b0;
        #1;
        chk("beats_drained", exp_beat_q.size(), 0);
        chk("rsp_drained", exp_rsp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ab;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 5'd0, 2, 0, 1'b0);
        run_txn(1'b1, 32'h0000_2000, '0, '0, 5'd3, 0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_3008, '0, '0, 5'd7, 1, 0, 1'b0);
        run_txn(1'b1, 32'h0000_2000, '0, '0, 5'd7, 0, 3, 1'b0);
        run_txn(1'b1, 32'h0000_6000, '0, '0, 5'd3, 0, 0, 1'b1);
        run_txn(1'b0, 32'h0000_7004, 32'h1234_5678, 4'b1100, 5'd0, 1, 1, 1'b0);
        run_txn(1'b0, 32'h0000_7008, 32'hCAFE_F00D, 4'b1111, 5'd0, 0, 0, 1'b1);
        run_txn(1'b1, 32'h0000_301C, '0, '0, 5'd20, 0, 0, 1'b0);
        run_txn(1'b1, 32'h0000_4444, '0, '0, 5'd0, 3, 1, 1'b0);

        // Reset during the second beat of an 8-beat read
        cfg_delay = 3; cfg_err_beat = 0; cfg_hang = 1'b0;
        expect_txn(1'b1, 32'h0000_4000, '0, '0, 5'd7, 0, 1'b0, ab);
        issue(1'b1, 32'h0000_4000, '0, '0, 5'd7);
        for (int g = 0; g < 50 && exp_rsp_q.size() > 7; g++) @(negedge clk);
        chk("rst_first_beat_seen", exp_rsp_q.size(), 7);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 chk_reset_vals("midrst");
        exp_beat_q.delete();
        exp_rsp_q.delete();
        ack_cyc_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_txn(1'b1, 32'h0000_5010, '0, '0, 5'd0, 1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit             rnw, hang;
            logic [AW-1:0]  addr;
            logic [DW-1:0]  data;
            logic [SW-1:0]  be;
            logic [4:0]     size;
            int             eb, dly;
            rnw  = 1'($urandom_range(0, 1));
            addr = $urandom;
            data = $urandom;
            be   = SW'($urandom_range(0, (1 << SW) - 1));
            size = 5'($urandom_range(0, 20));
            dly  = $urandom_range(0, 3);
            eb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, MAXB) : 0;
            hang = ($urandom_range(0, 9) == 0);
            run_txn(rnw, addr, data, be, size, dly, eb, hang);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
